fpdiv_arbiter: RTL and testbench

FPDIV_ARBITER -- requirements
Module: fpdiv_arbiter

---
 rtl/fpdiv_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/fpdiv_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_fpdiv_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpdiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fpdiv_pkg
//  Purpose  : Shared types and constants for the fpdiv request arbiter:
//             FSM state encoding, timeout result word, exception code and
//             default sizing parameters.
//  Revision : 1.0  initial release
// ============================================================================
package fpdiv_pkg;

    localparam int DEFAULT_N_REQ   = 4;
    localparam int DEFAULT_TIMEOUT = 64;

    // Result word and exception code reported when the divider never answers
    localparam logic [31:0] QNAN        = 32'h7FFF_FFFF;
    localparam logic [1:0]  EXC_INVALID = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Width of a requester index; a single requester still needs one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin pick: the first asserted bit of
//             i_valid at or after i_ptr, wrapping modulo N_REQ.
//  Ports    : i_valid     [N_REQ]  request vector
//             i_ptr       [IDW]    highest-priority index
//             o_grant     [N_REQ]  one-hot grant (zero when nothing valid)
//             o_grant_idx [IDW]    index of the granted bit
//             o_any       [1]      at least one request present
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter
    import fpdiv_pkg::*;
#(
    parameter  int N_REQ = DEFAULT_N_REQ,
    localparam int IDW   = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] i_valid,
    input  logic [IDW-1:0]   i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDW-1:0]   o_grant_idx,
    output logic             o_any
);

    // Walk offsets from farthest to nearest so the nearest valid requester
    // (smallest offset from the pointer) is the last one written and wins.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            if (i_valid[(int'(i_ptr) + off) % N_REQ]) begin
                o_grant_idx = IDW'((int'(i_ptr) + off) % N_REQ);
                o_any       = 1'b1;
            end
        end
        o_grant[o_grant_idx] = o_any;
    end

endmodule
`default_nettype wire

// File: rtl/fpdiv_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fpdiv_arbiter
//  Purpose  : Shares one floating-point divider among N_REQ requesters.
//             One operation in flight at a time: grant -> launch -> wait for
//             a rising DONE (or timeout) -> hold response until accepted.
//  Ports    : clock, reset_n            clock, synchronous active-low reset
//             req_valid/req_ready       per-requester handshake
//             req_a/req_b               packed operands, 32 bits per requester
//             rsp_valid/rsp_ready       shared response handshake
//             rsp_id/data/exc/to        response owner, result, exception,
//                                       timeout flag
//             div_start/div_a/div_b     divider launch pulse and operands
//             div_done/result/exc       divider completion level and result
//             busy                      high whenever not idle
//  Revision : 1.0  initial release
// ============================================================================
module fpdiv_arbiter
    import fpdiv_pkg::*;
#(
    parameter  int N_REQ   = DEFAULT_N_REQ,
    parameter  int TIMEOUT = DEFAULT_TIMEOUT,
    localparam int IDW     = idx_width(N_REQ)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [32*N_REQ-1:0] req_a,
    input  logic [32*N_REQ-1:0] req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [31:0]         rsp_data,
    output logic [1:0]          rsp_exc,
    output logic                rsp_to,
    output logic                div_start,
    output logic [31:0]         div_a,
    output logic [31:0]         div_b,
    input  logic                div_done,
    input  logic [31:0]         div_result,
    input  logic [1:0]          div_exc,
    output logic                busy
);

    localparam int             TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [IDW-1:0] IDX_LAST   = IDW'(N_REQ - 1);

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q,   ptr_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           done_q,  done_d;
    logic [IDW-1:0] id_q,    id_d;
    logic [31:0]    a_q,     a_d;
    logic [31:0]    b_q,     b_d;
    logic [31:0]    data_q,  data_d;
    logic [1:0]     exc_q,   exc_d;
    logic           to_q,    to_d;

    logic [N_REQ-1:0] grant_oh;
    logic [IDW-1:0]   grant_idx;
    logic             grant_any;
    logic             completion;
    logic             timed_out;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr (
        .i_valid     (req_valid),
        .i_ptr       (ptr_q),
        .o_grant     (grant_oh),
        .o_grant_idx (grant_idx),
        .o_any       (grant_any)
    );

    // Only a fresh rising DONE counts; a level still high from an earlier
    // operation was already registered into done_q and is ignored.
    assign completion = (state_q == ST_WAIT) && div_done && !done_q;
    assign timed_out  = (state_q == ST_WAIT) && (timer_q == TIMER_LAST);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            timer_q <= '0;
            done_q  <= 1'b0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            exc_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            timer_q <= timer_d;
            done_q  <= done_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            exc_q   <= exc_d;
            to_q    <= to_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (grant_any) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (completion || timed_out) state_d = ST_RESP;
            ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    always_comb begin
        ptr_d   = ptr_q;
        timer_d = timer_q;
        done_d  = div_done;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
        exc_d   = exc_q;
        to_d    = to_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    id_d = grant_idx;
                    a_d  = req_a[32*grant_idx +: 32];
                    b_d  = req_b[32*grant_idx +: 32];
                end
            end
            ST_ISSUE: timer_d = '0;
            ST_WAIT: begin
                timer_d = timer_q + TW'(1);
                // Completion takes priority over a coincident timeout
                if (completion) begin
                    data_d = div_result;
                    exc_d  = div_exc;
                    to_d   = 1'b0;
                end else if (timed_out) begin
                    data_d = QNAN;
                    exc_d  = EXC_INVALID;
                    to_d   = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) ptr_d = (id_q == IDX_LAST) ? '0 : id_q + IDW'(1);
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    // Ready is suppressed during a reset cycle so no requester believes it
    // was accepted by an operation the reset is about to discard.
    always_comb begin
        req_ready = '0;
        if ((state_q == ST_IDLE) && reset_n) req_ready = grant_oh;
        div_start = (state_q == ST_ISSUE);
        rsp_valid = (state_q == ST_RESP);
        busy      = (state_q != ST_IDLE);
    end

    assign div_a    = a_q;
    assign div_b    = b_q;
    assign rsp_id   = id_q;
    assign rsp_data = data_q;
    assign rsp_exc  = exc_q;
    assign rsp_to   = to_q;

endmodule
`default_nettype wire

// File: tb/tb_fpdiv_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fpdiv_arbiter
//  Purpose  : Self-checking bench for fpdiv_arbiter with a divider stub and a
//             cycle-indexed transaction model compared every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fpdiv_arbiter;

    localparam int N   = 4;
    localparam int TO  = 64;
    localparam int IDW = 2;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [32*N-1:0]  req_a = '0;
    logic [32*N-1:0]  req_b = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [IDW-1:0]   rsp_id;
    logic [31:0]      rsp_data;
    logic [1:0]       rsp_exc;
    logic             rsp_to;
    logic             div_start;
    logic [31:0]      div_a, div_b;
    logic             div_done = 1'b0;
    logic [31:0]      div_result = '0;
    logic [1:0]       div_exc = '0;
    logic             busy;

    always #5 clock = ~clock;

    fpdiv_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_exc(rsp_exc), .rsp_to(rsp_to),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_done(div_done), .div_result(div_result), .div_exc(div_exc),
        .busy(busy)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference quotient via double precision (operands are normal numbers)
    function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
        logic [10:0] ea, eb, eq;
        logic [63:0] da, db, dq;
        real q;
        ea = {3'b000, a[30:23]} + 11'd896;
        eb = {3'b000, b[30:23]} + 11'd896;
        da = {a[31], ea, a[22:0], 29'b0};
        db = {b[31], eb, b[22:0], 29'b0};
        q  = $bitstoreal(da) / $bitstoreal(db);
        dq = $realtobits(q);
        eq = dq[62:52] - 11'd896;
        return {dq[63], eq[7:0], dq[51:29]};
    endfunction

    function automatic logic [31:0] rnd_f();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 135)), 23'($urandom)};
    endfunction

    function automatic int first_from(input logic [N-1:0] v, input int p);
        for (int o = 0; o < N; o++) if (v[(p + o) % N]) return (p + o) % N;
        return -1;
    endfunction

    // ------------------------------------------------------------ stub controls
    bit          stub_launch = 0;
    logic [31:0] stub_a = '0, stub_b = '0;
    int          stub_delay = -1;      // <0: random latency
    bit          stub_never = 0;
    bit          stub_rand_never = 0;
    bit          stub_keep = 0;        // hold DONE high until the next launch

    // ------------------------------------------------------------ model state
    bit           m_busy = 0, m_post_reset = 0;
    int           m_owner = 0, m_acc = 0, m_rsp_start = -1, m_ptr = 0;
    logic [31:0]  m_a = '0, m_b = '0, m_data = '0;
    logic [1:0]   m_exc = '0;
    logic         m_to = 1'b0, m_prev_done = 1'b0;
    int           grant_log[$];
    logic [N-1:0] accepted_mask = '0;
    int           rsp_count = 0, last_id = 0, last_wait = 0, last_start_lat = 0;
    logic [31:0]  last_data = '0;
    logic [1:0]   last_exc = '0;
    logic         last_to = 1'b0;

    // Compare process: at each falling edge, check outputs against the model
    // and advance the model over the coming rising edge.
    always @(negedge clock) begin
        int g, k;
        logic [N-1:0] exp_rdy;
        cyc++;
        if (!reset_n) begin
            chk("ready_in_reset", 32'(req_ready), 32'd0);
            m_busy = 0; m_ptr = 0; m_prev_done = 1'b0; m_post_reset = 1;
        end else begin
            if (m_post_reset) begin
                chk("rst_req_ready", 32'(req_ready), 32'd0);
                chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
                chk("rst_rsp_id",    32'(rsp_id),    32'd0);
                chk("rst_rsp_data",  rsp_data,       32'd0);
                chk("rst_rsp_exc",   32'(rsp_exc),   32'd0);
                chk("rst_rsp_to",    32'(rsp_to),    32'd0);
                chk("rst_div_start", 32'(div_start), 32'd0);
                chk("rst_div_a",     div_a,          32'd0);
                chk("rst_div_b",     div_b,          32'd0);
                chk("rst_busy",      32'(busy),      32'd0);
                m_post_reset = 0;
            end
            if (!m_busy) begin
                g = first_from(req_valid, m_ptr);
                exp_rdy = '0;
                if (g >= 0) exp_rdy[g] = 1'b1;
                chk("idle_req_ready", 32'(req_ready), 32'(exp_rdy));
                chk("idle_busy",      32'(busy),      32'd0);
                chk("idle_div_start", 32'(div_start), 32'd0);
                chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
                if (g >= 0) begin
                    m_busy = 1; m_owner = g; m_acc = cyc; m_rsp_start = -1;
                    m_a = req_a[32*g +: 32];
                    m_b = req_b[32*g +: 32];
                    grant_log.push_back(g);
                    accepted_mask[g] = 1'b1;
                end
            end else begin
                chk("busy_req_ready", 32'(req_ready), 32'd0);
                chk("busy_busy",      32'(busy),      32'd1);
                if (cyc == m_acc + 1) begin
                    chk("issue_div_start", 32'(div_start), 32'd1);
                    chk("issue_div_a",     div_a,          m_a);
                    chk("issue_div_b",     div_b,          m_b);
                    chk("issue_rsp_valid", 32'(rsp_valid), 32'd0);
                    last_start_lat = cyc - m_acc;
                    stub_a = m_a; stub_b = m_b; stub_launch = 1;
                end else if (m_rsp_start < 0) begin
                    chk("wait_div_start", 32'(div_start), 32'd0);
                    chk("wait_div_a",     div_a,          m_a);
                    chk("wait_div_b",     div_b,          m_b);
                    chk("wait_rsp_valid", 32'(rsp_valid), 32'd0);
                    k = cyc - (m_acc + 2);
                    if (div_done && !m_prev_done) begin
                        m_data = div_result; m_exc = div_exc; m_to = 1'b0;
                        m_rsp_start = cyc + 1; last_wait = k + 1;
                    end else if (k == TO - 1) begin
                        m_data = 32'h7FFF_FFFF; m_exc = 2'b11; m_to = 1'b1;
                        m_rsp_start = cyc + 1; last_wait = k + 1;
                    end
                end else begin
                    chk("resp_div_start", 32'(div_start), 32'd0);
                    chk("resp_rsp_valid", 32'(rsp_valid), 32'd1);
                    chk("resp_rsp_id",    32'(rsp_id),    32'(m_owner));
                    chk("resp_rsp_data",  rsp_data,       m_data);
                    chk("resp_rsp_exc",   32'(rsp_exc),   32'(m_exc));
                    chk("resp_rsp_to",    32'(rsp_to),    32'(m_to));
                    if (rsp_ready) begin
                        m_busy = 0; m_ptr = (m_owner + 1) % N;
                        last_id = m_owner; last_data = m_data;
                        last_exc = m_exc; last_to = m_to;
                        rsp_count++;
                    end
                end
            end
            m_prev_done = div_done;
        end
    end

    // ------------------------------------------------------------ divider stub
    initial begin : stub
        logic [31:0] q;
        logic [1:0]  e;
        int cnt, hold;
        bit pending;
        q = '0; e = '0; cnt = 0; hold = 0; pending = 0;
        forever begin
            @(posedge clock); #1;
            if (stub_launch) begin
                stub_launch = 0;
                q = fdiv(stub_a, stub_b);
                e = 2'($urandom_range(0, 3));
                if (stub_never || (stub_rand_never && $urandom_range(0, 9) == 0)) pending = 0;
                else begin
                    pending = 1;
                    cnt = (stub_delay >= 0) ? stub_delay : int'($urandom_range(0, 6));
                end
            end else if (pending) begin
                if (cnt > 0) cnt--;
                else if (div_done) div_done = 1'b0;   // need a fresh rising edge
                else begin
                    div_done = 1'b1; div_result = q; div_exc = e;
                    hold = $urandom_range(1, 5); pending = 0;
                end
            end else if (div_done && !stub_keep) begin
                if (hold > 0) hold--;
                else div_done = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    bit auto_drop = 1;

    task automatic tick();
        @(posedge clock); #1;
        if (auto_drop) req_valid = req_valid & ~accepted_mask;
        accepted_mask = '0;
    endtask

    task automatic reset_dut(input int cycles);
        req_valid = '0;
        reset_n = 1'b0;
        repeat (cycles) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int b = 0;
        while (rsp_count < target && b < budget) begin tick(); b++; end
        chk("rsp_arrived", 32'(rsp_count >= target), 32'd1);
    endtask

    initial begin
        int n0, gl0;
        logic [31:0] sv_data;
        logic [1:0]  sv_exc;
        logic [IDW-1:0] sv_id;
        logic sv_to;
        int b;

        reset_dut(2);

        // Single request: 5.0 / 2.0
        stub_delay = 2; rsp_ready = 1'b1; n0 = rsp_count;
        req_a[31:0] = 32'h40A0_0000; req_b[31:0] = 32'h4000_0000; req_valid = 4'b0001;
        wait_rsp(n0 + 1, 50);
        chk("single_data",      last_data,            32'h4020_0000);
        chk("single_id",        32'(last_id),         32'd0);
        chk("single_to",        32'(last_to),         32'd0);
        chk("single_start_lat", 32'(last_start_lat),  32'd1);

        // Fairness: all four after reset, then 0 and 2 again
        reset_dut(1);
        stub_delay = -1; gl0 = grant_log.size(); n0 = rsp_count;
        for (int i = 0; i < N; i++) begin req_a[32*i +: 32] = rnd_f(); req_b[32*i +: 32] = rnd_f(); end
        req_valid = 4'b1111;
        wait_rsp(n0 + 4, 200);
        req_valid = 4'b0101;
        wait_rsp(n0 + 5, 100);
        chk("ptr_after_0", 32'(dut.ptr_q), 32'd1);
        wait_rsp(n0 + 6, 100);
        chk("grant_count", 32'(grant_log.size() - gl0), 32'd6);
        if (grant_log.size() - gl0 == 6) begin
            chk("grant_0", 32'(grant_log[gl0 + 0]), 32'd0);
            chk("grant_1", 32'(grant_log[gl0 + 1]), 32'd1);
            chk("grant_2", 32'(grant_log[gl0 + 2]), 32'd2);
            chk("grant_3", 32'(grant_log[gl0 + 3]), 32'd3);
            chk("grant_4", 32'(grant_log[gl0 + 4]), 32'd0);
            chk("grant_5", 32'(grant_log[gl0 + 5]), 32'd2);
        end

        // Back-pressure: response held 10 cycles while another requester waits
        stub_delay = 1; rsp_ready = 1'b0; n0 = rsp_count;
        req_a[63:32] = rnd_f(); req_b[63:32] = rnd_f(); req_valid = 4'b0010;
        b = 0;
        while (!rsp_valid && b < 50) begin tick(); b++; end
        chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        req_a[127:96] = rnd_f(); req_b[127:96] = rnd_f(); req_valid = 4'b1000;
        sv_data = rsp_data; sv_exc = rsp_exc; sv_id = rsp_id; sv_to = rsp_to;
        repeat (10) tick();
        chk("bp_valid_held", 32'(rsp_valid), 32'd1);
        chk("bp_data_stable", rsp_data,      sv_data);
        chk("bp_exc_stable",  32'(rsp_exc),  32'(sv_exc));
        chk("bp_id_stable",   32'(rsp_id),   32'(sv_id));
        chk("bp_to_stable",   32'(rsp_to),   32'(sv_to));
        chk("bp_id_value",    32'(rsp_id),   32'd1);
        rsp_ready = 1'b1;
        wait_rsp(n0 + 2, 100);
        chk("bp_second_id", 32'(last_id), 32'd3);

        // Timeout: divider never answers
        stub_never = 1; n0 = rsp_count;
        req_a[95:64] = rnd_f(); req_b[95:64] = rnd_f(); req_valid = 4'b0100;
        wait_rsp(n0 + 1, 150);
        chk("to_data", last_data,        32'h7FFF_FFFF);
        chk("to_exc",  32'(last_exc),    32'd3);
        chk("to_flag", 32'(last_to),     32'd1);
        chk("to_wait", 32'(last_wait),   32'd64);
        stub_never = 0;

        // Stale DONE: level held high from the previous op into the next
        stub_keep = 1; stub_delay = 0; n0 = rsp_count;
        req_a[31:0] = 32'h4120_0000; req_b[31:0] = 32'h4000_0000; req_valid = 4'b0001;
        wait_rsp(n0 + 1, 50);
        chk("stale_first_data", last_data, 32'h40A0_0000);
        stub_delay = 10;
        req_a[95:64] = 32'h4040_0000; req_b[95:64] = 32'h3F80_0000; req_valid = 4'b0100;
        wait_rsp(n0 + 2, 100);
        chk("stale_waited", 32'(last_wait >= 12), 32'd1);
        chk("stale_data",   last_data,            32'h4040_0000);
        stub_keep = 0;
        repeat (8) tick();

        // Reset during WAIT; the abandoned op's DONE must produce nothing
        stub_delay = 8; n0 = rsp_count;
        req_a[63:32] = rnd_f(); req_b[63:32] = rnd_f(); req_valid = 4'b0010;
        repeat (4) tick();
        chk("mid_busy_before", 32'(busy), 32'd1);
        reset_dut(1);
        repeat (20) tick();
        chk("mid_no_rsp",  32'(rsp_count), 32'(n0));
        chk("mid_busy",    32'(busy),      32'd0);
        chk("mid_rsp_val", 32'(rsp_valid), 32'd0);

        // Randomised traffic
        auto_drop = 0; stub_delay = -1; stub_rand_never = 1;
        repeat (1500) begin
            tick();
            req_valid = 4'($urandom);
            for (int i = 0; i < N; i++) begin req_a[32*i +: 32] = rnd_f(); req_b[32*i +: 32] = rnd_f(); end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = '0; rsp_ready = 1'b1; stub_rand_never = 0;
        b = 0;
        while (busy && b < 200) begin tick(); b++; end
        chk("drain_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
